// File: rtl/line_memory_banked.sv
// rtl/line_memory_banked.sv - banked single-port line memory with valid/ready requests and byte-strobe RMW
// Optional LINEMEM_PERF_CNT_EN adds 32-bit read/write/RMW event counters.
module sram_sp_16384x64 (
  output logic [63:0] Q,
  input  logic        CLK,
  input  logic        CEN,
  input  logic        GWEN,
  input  logic [13:0] A,
  input  logic [63:0] D,
  input  logic [2:0]  EMA,
  input  logic [1:0]  EMAW,
  input  logic        EMAS,
  input  logic        STOV,
  input  logic        RET1N
);
  logic [63:0] mem [16384];
  logic        unused_cfg;

  assign unused_cfg = ^{EMA, EMAW, EMAS, STOV};

  // Read data appears after the enabling edge; Q holds during writes and idle cycles.
  always_ff @(posedge CLK) begin
    if (!CEN && RET1N) begin
      if (!GWEN) mem[A] <= D;
      else       Q <= mem[A];
    end
  end
endmodule

module line_memory_banked #(
  parameter  int DATA_W      = 64,
  parameter  int BANK_ADDR_W = 14,
  parameter  int NUM_BANKS   = 2,
  localparam int BANK_SEL_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
  localparam int ADDR_W      = BANK_ADDR_W + BANK_SEL_W,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        EMA_EMAW,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef LINEMEM_PERF_CNT_EN
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_wr_cnt,
  output logic [31:0]       perf_rmw_cnt,
`endif
  output logic              busy
);
  localparam int SEL_W = (BANK_SEL_W > 0) ? BANK_SEL_W : 1;

  typedef enum logic [0:0] {ST_IDLE, ST_RMW} state_t;

  state_t                 state;
  logic [SEL_W-1:0]       req_sel;
  logic [SEL_W-1:0]       rsp_sel;
  logic [SEL_W-1:0]       lat_sel;
  logic [BANK_ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0]      lat_wdata;
  logic [BE_W-1:0]        lat_be;
  logic [DATA_W-1:0]      rsp_hold;
  logic [DATA_W-1:0]      rsp_q;
  logic [DATA_W-1:0]      rmw_q;
  logic [DATA_W-1:0]      merged;
  logic                   accept;
  logic                   do_read;
  logic                   do_full;
  logic                   do_rmw;
  logic                   unused_ema;

  logic [DATA_W-1:0]      bank_q [NUM_BANKS];
  logic [NUM_BANKS-1:0]   bank_cen;
  logic [NUM_BANKS-1:0]   bank_gwen;
  logic [BANK_ADDR_W-1:0] bank_a;
  logic [DATA_W-1:0]      bank_d;

  assign unused_ema = ^EMA_EMAW;

  generate
    if (NUM_BANKS > 1) begin : g_sel
      assign req_sel = req_addr[ADDR_W-1:BANK_ADDR_W];
    end else begin : g_nosel
      assign req_sel = '0;
    end
  endgenerate

  assign accept  = req_valid && req_ready;
  assign do_read = accept && !req_we;
  assign do_full = accept && req_we && (&req_be);
  assign do_rmw  = accept && req_we && !(&req_be) && (|req_be);

  assign rmw_q = bank_q[lat_sel];
  assign rsp_q = bank_q[rsp_sel];

  always_comb begin
    merged = rmw_q;
    for (int i = 0; i < BE_W; i++) begin
      if (lat_be[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
    end
  end

  // Bank control is combinational on the state so an async reset mid-RMW drops the merged write.
  always_comb begin
    bank_a    = (state == ST_RMW) ? lat_addr : req_addr[BANK_ADDR_W-1:0];
    bank_d    = (state == ST_RMW) ? merged   : req_wdata;
    bank_cen  = '1;
    bank_gwen = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (state == ST_RMW) begin
        if (lat_sel == SEL_W'(b)) begin
          bank_cen[b]  = 1'b0;
          bank_gwen[b] = 1'b0;
        end
      end else if ((do_read || do_full || do_rmw) && req_sel == SEL_W'(b)) begin
        bank_cen[b]  = 1'b0;
        bank_gwen[b] = !do_full;
      end
    end
  end

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_W-1:0] q;
      assign bank_q[b] = q;
      if (DATA_W == 64 && BANK_ADDR_W == 14) begin : g_macro
        sram_sp_16384x64 u_sram (
          .Q     (q),
          .CLK   (clk),
          .CEN   (bank_cen[b]),
          .GWEN  (bank_gwen[b]),
          .A     (bank_a),
          .D     (bank_d),
          .EMA   (EMA_EMAW[6:4]),
          .EMAW  (EMA_EMAW[1:0]),
          .EMAS  (1'b0),
          .STOV  (1'b0),
          .RET1N (1'b1)
        );
      end else begin : g_beh
        logic [DATA_W-1:0] mem [2**BANK_ADDR_W];
        always_ff @(posedge clk) begin
          if (!bank_cen[b]) begin
            if (!bank_gwen[b]) mem[bank_a] <= bank_d;
            else               q <= mem[bank_a];
          end
        end
      end
    end
  endgenerate

  // Response data comes straight from the bank in its valid cycle and is held afterwards.
  assign rsp_rdata = rsp_valid ? rsp_q : rsp_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sel   <= '0;
      rsp_hold  <= '0;
      lat_sel   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      rsp_valid <= do_read;
      if (do_read)   rsp_sel  <= req_sel;
      if (rsp_valid) rsp_hold <= rsp_q;
      case (state)
        ST_IDLE: begin
          if (do_rmw) begin
            lat_sel   <= req_sel;
            lat_addr  <= req_addr[BANK_ADDR_W-1:0];
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            state     <= ST_RMW;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_RMW: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef LINEMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_rmw_cnt <= '0;
    end else begin
      if (do_read)           perf_rd_cnt  <= perf_rd_cnt + 32'd1;
      if (accept && req_we)  perf_wr_cnt  <= perf_wr_cnt + 32'd1;
      if (do_rmw)            perf_rmw_cnt <= perf_rmw_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_line_memory_banked.sv
// tb/tb_line_memory_banked.sv - directed scoreboard bench for line_memory_banked
// Covers the default build and a 4-bank 32-bit instance; checks perf counters when LINEMEM_PERF_CNT_EN is set.
module tb_line_memory_banked;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ema_emaw = 8'h00;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [14:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_be = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        busy;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_we = 1'b0;
  logic [11:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_be = '0;
  logic        s_rsp_valid;
  logic [31:0] s_rsp_rdata;
  logic        s_busy;

`ifdef LINEMEM_PERF_CNT_EN
  logic [31:0] d_rd_cnt, d_wr_cnt, d_rmw_cnt;
  logic [31:0] s_rd_cnt, s_wr_cnt, s_rmw_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] s_exp_q[$];

  always #5 clk = ~clk;

  line_memory_banked u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EMA_EMAW  (ema_emaw),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
`ifdef LINEMEM_PERF_CNT_EN
    .perf_rd_cnt  (d_rd_cnt),
    .perf_wr_cnt  (d_wr_cnt),
    .perf_rmw_cnt (d_rmw_cnt),
`endif
    .busy      (busy)
  );

  line_memory_banked #(.DATA_W(32), .BANK_ADDR_W(10), .NUM_BANKS(4)) u_sweep (
    .clk       (clk),
    .rst_n     (rst_n),
    .EMA_EMAW  (ema_emaw),
    .req_valid (s_valid),
    .req_ready (s_ready),
    .req_we    (s_we),
    .req_addr  (s_addr),
    .req_wdata (s_wdata),
    .req_be    (s_be),
    .rsp_valid (s_rsp_valid),
    .rsp_rdata (s_rsp_rdata),
`ifdef LINEMEM_PERF_CNT_EN
    .perf_rd_cnt  (s_rd_cnt),
    .perf_wr_cnt  (s_wr_cnt),
    .perf_rmw_cnt (s_rmw_cnt),
`endif
    .busy      (s_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input bit sweep);
    int n = 0;
    while ((sweep ? s_ready : req_ready) !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic d_req(input logic we, input logic [14:0] a, input logic [63:0] d, input logic [7:0] be);
    wait_ready(1'b0);
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic d_rd(input logic [14:0] a, input logic [63:0] exp);
    exp_q.push_back(exp);
    d_req(1'b0, a, 64'd0, 8'h00);
  endtask

  task automatic s_req(input logic we, input logic [11:0] a, input logic [31:0] d);
    wait_ready(1'b1);
    s_we = we; s_addr = a; s_wdata = d; s_be = 4'hF; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
      else chk("rsp_data", rsp_rdata, exp_q.pop_front());
    end
    if (s_rsp_valid === 1'b1) begin
      if (s_exp_q.size() == 0) chk("sweep_unexpected_rsp", 64'd1, 64'd0);
      else chk("sweep_rsp_data", {32'd0, s_rsp_rdata}, {32'd0, s_exp_q.pop_front()});
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Two banks, same in-bank address, back-to-back reads
    d_req(1'b1, 15'h0003, 64'hA5A5_0000_0000_0001, 8'hFF);
    d_req(1'b1, 15'h4003, 64'hDEAD_BEEF_0000_0002, 8'hFF);
    d_rd(15'h0003, 64'hA5A5_0000_0000_0001);
    chk("b2b_valid0", {63'd0, rsp_valid}, 64'd1);
    d_rd(15'h4003, 64'hDEAD_BEEF_0000_0002);
    chk("b2b_valid1", {63'd0, rsp_valid}, 64'd1);
    @(posedge clk); #1;
    chk("b2b_valid_end", {63'd0, rsp_valid}, 64'd0);
    chk("rdata_hold", rsp_rdata, 64'hDEAD_BEEF_0000_0002);

    // Partial write: one stall cycle
    d_req(1'b1, 15'h0010, 64'h1111_2222_3333_4444, 8'hFF);
    d_req(1'b1, 15'h0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    chk("rmw_ready", {63'd0, req_ready}, 64'd0);
    chk("rmw_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    chk("rmw_ready_back", {63'd0, req_ready}, 64'd1);
    chk("rmw_busy_clear", {63'd0, busy}, 64'd0);
    d_rd(15'h0010, 64'h1111_2222_FFFF_FFFF);

    // Zero strobe then full strobe
    d_req(1'b1, 15'h0010, 64'h0123_4567_89AB_CDEF, 8'h00);
    chk("zero_be_ready", {63'd0, req_ready}, 64'd1);
    chk("zero_be_busy", {63'd0, busy}, 64'd0);
    d_rd(15'h0010, 64'h1111_2222_FFFF_FFFF);
    d_req(1'b1, 15'h0010, 64'h0123_4567_89AB_CDEF, 8'hFF);
    chk("full_be_ready", {63'd0, req_ready}, 64'd1);
    d_rd(15'h0010, 64'h0123_4567_89AB_CDEF);

    // Partial write in the upper bank, high bytes
    d_req(1'b1, 15'h4003, 64'h7777_0000_0000_0000, 8'hC0);
    d_rd(15'h4003, 64'h7777_BEEF_0000_0002);
    d_rd(15'h0003, 64'hA5A5_0000_0000_0001);

    // Reset during the RMW cycle drops the merged write
    d_req(1'b1, 15'h0020, 64'hCAFE_F00D_1234_5678, 8'hFF);
    @(posedge clk); #1;
    chk("sb_empty_pre_rst", 64'(exp_q.size()), 64'd0);
    d_req(1'b1, 15'h0020, 64'h0000_0000_0000_0000, 8'h03);
    chk("rmw2_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, req_ready}, 64'd1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("midrst_rdata", rsp_rdata, 64'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    d_rd(15'h0020, 64'hCAFE_F00D_1234_5678);
    @(posedge clk); #1;

    // Four-bank, 32-bit instance
    for (int k = 0; k < 4; k++) s_req(1'b1, 12'(k * 1024 + 5), 32'hC0DE_0000 + 32'(k * 17));
    for (int k = 0; k < 4; k++) begin
      s_exp_q.push_back(32'hC0DE_0000 + 32'(k * 17));
      s_req(1'b0, 12'(k * 1024 + 5), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
`ifdef LINEMEM_PERF_CNT_EN
    chk("perf_wr", {32'd0, s_wr_cnt}, 64'd4);
    chk("perf_rd", {32'd0, s_rd_cnt}, 64'd4);
    chk("perf_rmw", {32'd0, s_rmw_cnt}, 64'd0);
`endif
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("sweep_sb_empty", 64'(s_exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
